mdu_sequencer: RTL

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

---
 rtl/mdu_pkg.sv | 33 +++
 rtl/mdu_sequencer_if.sv | 29 ++
 rtl/mdu_shift_core.sv | 93 +++++++++
 rtl/mdu_sequencer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM state type,
// Funct3 op codes, default operand width and small op-decode helpers.
package mdu_pkg;

  localparam int MDU_XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } mdu_state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // SrcA is signed for MULH, MULHSU, DIV and REM.
  function automatic logic op_a_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // SrcB is signed for MULH, DIV and REM (MULHSU keeps it unsigned).
  function automatic logic op_b_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// Request/response bundle between the pipeline and the multiply/divide
// sequencer.
// Handshake: start is a request that is taken only while busy is low and
// flush is low; once taken, busy stays high until the cycle after the
// one-cycle done pulse, and Result holds its value until the next done.
interface mdu_sequencer_if
  import mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
);
  logic            start;
  logic            flush;
  logic [2:0]      Funct3;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] Result;

  modport master (
    output start, flush, Funct3, SrcA, SrcB,
    input  busy, done, Result
  );

  modport slave (
    input  start, flush, Funct3, SrcA, SrcB,
    output busy, done, Result
  );
endinterface

// File: rtl/mdu_shift_core.sv
// Iterative datapath: hi/lo shift register pair plus the operand register
// and one XLEN+1-bit adder. Multiply is shift-add on magnitudes (product
// ends up in {hi,lo}); divide (only with MDU_DIV_EN) is restoring division
// with the remainder in hi and the quotient in lo.
module mdu_shift_core
  import mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
`ifdef MDU_DIV_EN
  input  logic            is_div,
`endif
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opb_q, opb_d;

  logic [XLEN:0] add_a;
  logic [XLEN:0] add_b;
  logic [XLEN:0] sum;

  // Shared adder: multiply adds the multiplicand to hi; divide subtracts
  // the divisor from {hi, next dividend bit}.
  always_comb begin
    add_a = {1'b0, hi_q};
    add_b = {1'b0, opb_q};
    sum   = add_a + add_b;
`ifdef MDU_DIV_EN
    if (is_div) begin
      add_a = {hi_q, lo_q[XLEN-1]};
      sum   = add_a + ~add_b + (XLEN+1)'(1);
    end
`endif
  end

  // One iteration per step; load seeds the registers with the magnitudes.
  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    opb_d = opb_q;
    if (load) begin
      hi_d  = '0;
      lo_d  = a_mag;
      opb_d = b_mag;
    end else if (step) begin
`ifdef MDU_DIV_EN
      if (is_div) begin
        // MSB of the difference is its sign: negative means restore.
        if (!sum[XLEN]) begin
          hi_d = sum[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = add_a[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
      end else
`endif
      begin
        if (lo_q[0]) begin
          {hi_d, lo_d} = {sum, lo_q[XLEN-1:1]};
        end else begin
          {hi_d, lo_d} = {1'b0, hi_q, lo_q[XLEN-1:1]};
        end
      end
    end
  end

  // Datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      opb_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      opb_q <= opb_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer: FSM (IDLE/CALC/FIXUP/DONE),
// iteration counter, operand sign handling, divide special cases and the
// registered Result. Normal ops take XLEN CALC cycles plus one FIXUP cycle;
// special cases go straight from IDLE to DONE.
// Optional feature: define MDU_DIV_EN to build the divide path
// (Funct3 100..111). Without it those ops complete at once with Result 0.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic                  clk,
  input  logic                  reset,
  mdu_sequencer_if.slave        bus,
  output mdu_state_e            dbg_state
);

  localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
`ifdef MDU_DIV_EN
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
`endif

  mdu_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            accept;
  logic            special;
  logic [XLEN-1:0] spec_result;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            core_load, core_step;
  logic [XLEN-1:0] hi, lo;

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   mul_res, div_res, fix_result;
`ifdef MDU_DIV_EN
  logic [XLEN-1:0]   div_raw;
`endif

  // flush outranks start, so a start in the same cycle is dropped.
  assign accept = (state_q == ST_IDLE) && bus.start && !bus.flush;

  // State register and bookkeeping flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  // Next-state logic; flush returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (bus.start) state_d = special ? ST_DONE : ST_CALC;
        ST_CALC:  if (cnt_q == CNT_W'(XLEN - 1)) state_d = ST_FIXUP;
        ST_FIXUP: state_d = ST_DONE;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are pure state decodes plus the held result register.
  always_comb begin
    bus.busy   = (state_q != ST_IDLE);
    bus.done   = (state_q == ST_DONE);
    bus.Result = result_q;
    dbg_state  = state_q;
  end

  // Special-case detection for divide ops that never enter CALC.
  always_comb begin
    special     = 1'b0;
    spec_result = '0;
`ifdef MDU_DIV_EN
    if (bus.Funct3[2]) begin
      if (bus.SrcB == '0) begin
        special     = 1'b1;
        spec_result = bus.Funct3[1] ? bus.SrcA : '1;
      end else if (!bus.Funct3[0] && (bus.SrcA == MIN_NEG) && (bus.SrcB == '1)) begin
        special     = 1'b1;
        spec_result = bus.Funct3[1] ? '0 : MIN_NEG;
      end
    end
`else
    special = bus.Funct3[2];
`endif
  end

  // Operand magnitudes fed to the core; the sign is restored in FIXUP.
  always_comb begin
    a_neg = op_a_signed(bus.Funct3) && bus.SrcA[XLEN-1];
    b_neg = op_b_signed(bus.Funct3) && bus.SrcB[XLEN-1];
    a_mag = a_neg ? -bus.SrcA : bus.SrcA;
    b_mag = b_neg ? -bus.SrcB : bus.SrcB;
  end

  // FIXUP result: negate the magnitude result when the sign calls for it.
  always_comb begin
    prod     = {hi, lo};
    prod_fix = neg_q ? -prod : prod;
    mul_res  = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
`ifdef MDU_DIV_EN
    div_raw  = op_q[1] ? hi : lo;
    div_res  = neg_q ? -div_raw : div_raw;
`else
    div_res  = '0;
`endif
    fix_result = op_q[2] ? div_res : mul_res;
  end

  // Operation bookkeeping: latch op on accept, count iterations, capture result.
  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    result_d  = result_q;
    core_load = 1'b0;
    core_step = 1'b0;
    if (accept) begin
      op_d  = bus.Funct3;
      cnt_d = '0;
      // Remainder takes the dividend sign; everything else sign(A)^sign(B).
      neg_d = (bus.Funct3[2] && bus.Funct3[1]) ? a_neg : (a_neg ^ b_neg);
      if (special) begin
        result_d = spec_result;
      end else begin
        core_load = 1'b1;
      end
    end
    if ((state_q == ST_CALC) && !bus.flush) begin
      core_step = 1'b1;
      cnt_d     = cnt_q + CNT_W'(1);
    end
    if ((state_q == ST_FIXUP) && !bus.flush) begin
      result_d = fix_result;
    end
  end

  mdu_shift_core #(.XLEN(XLEN)) u_core (
    .clk   (clk),
    .reset (reset),
    .load  (core_load),
    .step  (core_step),
`ifdef MDU_DIV_EN
    .is_div(op_q[2]),
`endif
    .a_mag (a_mag),
    .b_mag (b_mag),
    .hi    (hi),
    .lo    (lo)
  );

endmodule
